pd_block_decoder: RTL and testbench
===================================

# pd_block_decoder

Parametrised next-generation packet decoder for the miner's host link. Deserialises a framed host packet (type byte, difficulty, block header) into shadow registers, commits it atomically on a well-formed end of packet, and hands each of NUM_CH hash cores its own interleaved nonce stream. Hash cores keep using the previous block while a new one is received. It sits between the USB RX byte stream and the hash-core array, replacing the fixed single-channel decoder.

## Interface
- NUM_CH, 2: hash channels (1..8).
- DIFF_BYTES, 32: difficulty field length in bytes.
- HDR_BYTES, 80: block header length in bytes.
- NONCE_OFS, 76: byte offset of the 32-bit little-endian nonce field inside the header (≤ HDR_BYTES-4).
- TIMEOUT, 1000: maximum idle cycles allowed between bytes inside a packet (≥ 2).
- clk  in  1  system clock; everything is on its rising edge.
- n_rst  in  1  synchronous, active-low reset.
- write_enable  in  1  rx_data/eop valid this cycle (one byte per asserted cycle).
- rx_data  in  8  received byte.
- eop  in  1  end of packet; meaningful only with write_enable.
- increment  in  NUM_CH  per-channel "nonce consumed" pulse.
- header_out  out  HDR_BYTES*8  committed header; byte k at [8k+7:8k].
- difficulty  out  DIFF_BYTES*8  committed difficulty; first received byte is MSB.
- nonce  out  NUM_CH*32  channel c nonce at [32c+31:32c].
- new_block  out  1  one-cycle pulse on commit.
- quit_hash  out  1  one-cycle pulse on accepted abort packet.
- p_error  out  1  one-cycle pulse on protocol error.
- nonce_wrap  out  NUM_CH  one-cycle pulse when that channel's nonce wraps.
- host_ready  out  1  high in IDLE.

## Operation
- Packet: type byte, then DIFF_BYTES difficulty bytes, then HDR_BYTES header bytes; eop must accompany the last header byte. Abort packet: a single byte 0x5A with eop.
- States: IDLE, RX_DIFF, RX_HDR, DRAIN.
- IDLE: byte 0xA5 with eop=0 -> RX_DIFF, count=0. Byte 0x5A with eop=1 -> quit_hash, stay. Any other byte or eop combination -> p_error; -> IDLE if eop=1, else DRAIN.
- RX_DIFF/RX_HDR: each byte is written to the shadow buffer at the counter position, then the counter increments. After DIFF_BYTES bytes -> RX_HDR, count=0. eop on a byte that is not the final header byte -> p_error, IDLE, shadow buffer discarded. Final header byte without eop -> p_error, DRAIN. Final header byte with eop -> commit, IDLE.
- Commit: header_out/difficulty <= shadow; nonce[c] <= base + c, where base = header bytes NONCE_OFS..+3 (little-endian); new_block pulse.
- Timeout counter clears on every accepted byte and runs in RX_DIFF, RX_HDR and DRAIN. On reaching TIMEOUT -> IDLE. p_error pulses if the timeout occurs in RX_*, but not in DRAIN.
- DRAIN: discard bytes until a byte with eop arrives -> IDLE (no pulse).
- Nonce lanes: increment[c] -> nonce[c] += NUM_CH, mod 2^32. If the add carries out, nonce_wrap[c] pulses. A commit in the same cycle wins over the increment (increment is dropped).
- increment is honoured in every state, including during reception.

## Timing
- Reset values: header_out, difficulty, nonce, all pulses = 0; state IDLE; host_ready = 1.
- All outputs are registered. new_block, header_out, difficulty and nonce all update in the cycle after the final-byte edge.
- quit_hash and p_error assert in the cycle after the causing byte or the timeout.
- A nonce update is visible one cycle after increment.
- A new packet may start in the cycle immediately after commit; back-to-back bytes are legal every cycle.
- Reset mid-packet discards the shadow buffer and the counters, with no pulses.

## Structure
- pd_pkg: state enum pd_state_t; constants PKT_NEW = 8'hA5, PKT_ABORT = 8'h5A.
- Counter widths: $clog2(max(DIFF_BYTES, HDR_BYTES)+1) and $clog2(TIMEOUT+1).
- Sub-module pd_nonce_lane (load, increment, step, 32-bit value, wrap pulse), instantiated NUM_CH times in a generate loop.
- FSM, shadow buffer and timeout live in pd_block_decoder.

## Test plan
Bench parameters: NUM_CH=2, TIMEOUT=16, other parameters at their defaults.
- Valid packet, header nonce bytes 78 56 34 12 -> new_block once; nonce[0] = 0x12345678, nonce[1] = 0x12345679; difficulty MSB equals the first difficulty byte.
- After commit, increment=2'b01 three times -> nonce[0] = 0x1234567E; nonce[1] unchanged.
- Valid packet, then a second packet truncated by eop at header byte 40 -> p_error; header_out still equals packet 1; host_ready=1.
- Nonce base 0xFFFFFFFE, increment[0] -> nonce[0] = 0x00000000 and nonce_wrap[0] pulses. Increment and commit together -> committed value wins.
- 20 idle cycles after difficulty byte 5 -> p_error at cycle 16; a following valid packet commits.
- Byte 0x33 without eop, then 10 bytes, then a byte with eop -> a single p_error, no new_block, IDLE. Then 0x5A with eop -> quit_hash.

Source files
------------

// File: rtl/pd_pkg.sv
// Shared types and constants for the host-link block decoder.
package pd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RX_DIFF = 2'd1,
      RX_HDR  = 2'd2,
      DRAIN   = 2'd3
   } pd_state_t;

   localparam logic [7:0] PKT_NEW   = 8'hA5;
   localparam logic [7:0] PKT_ABORT = 8'h5A;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pd_nonce_lane.sv
// One hash channel's nonce register: loads on commit, otherwise steps by the channel stride.
module pd_nonce_lane (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        load_i,
   input  logic [31:0] load_val_i,
   input  logic        inc_i,
   input  logic [31:0] step_i,
   output logic [31:0] value_o,
   output logic        wrap_o
);

   logic [32:0] sum;

   assign sum = {1'b0, value_o} + {1'b0, step_i};

   // Commit has priority; a same-cycle increment is dropped.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         value_o <= '0;
         wrap_o  <= 1'b0;
      end else if (load_i) begin
         value_o <= load_val_i;
         wrap_o  <= 1'b0;
      end else if (inc_i) begin
         value_o <= sum[31:0];
         wrap_o  <= sum[32];
      end else begin
         wrap_o  <= 1'b0;
      end
   end

endmodule

// File: rtl/pd_block_decoder.sv
// Host packet decoder: shadows difficulty/header while receiving, commits atomically on
// a well-formed end of packet and seeds one interleaved nonce lane per hash channel.
module pd_block_decoder
   import pd_pkg::*;
#(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned DIFF_BYTES = 32,
   parameter int unsigned HDR_BYTES  = 80,
   parameter int unsigned NONCE_OFS  = 76,
   parameter int unsigned TIMEOUT    = 1000
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    write_enable,
   input  logic [7:0]              rx_data,
   input  logic                    eop,
   input  logic [NUM_CH-1:0]       increment,
   output logic [HDR_BYTES*8-1:0]  header_out,
   output logic [DIFF_BYTES*8-1:0] difficulty,
   output logic [NUM_CH*32-1:0]    nonce,
   output logic                    new_block,
   output logic                    quit_hash,
   output logic                    p_error,
   output logic [NUM_CH-1:0]       nonce_wrap,
   output logic                    host_ready
);

   localparam int unsigned CNT_W = $clog2(max_u(DIFF_BYTES, HDR_BYTES) + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   pd_state_t               state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [TO_W-1:0]         to_q, to_d;
   logic [DIFF_BYTES*8-1:0] diff_sh_q;
   logic [HDR_BYTES*8-1:0]  hdr_sh_q;
   logic [HDR_BYTES*8-1:0]  hdr_full;
   logic [31:0]             nonce_base;
   logic                    to_hit, last_diff, last_hdr;
   logic                    commit, quit_d, perr_d, wr_diff, wr_hdr;

   assign to_hit    = !write_enable && (state_q != IDLE) && (to_q == TO_W'(TIMEOUT - 1));
   assign last_diff = (cnt_q == CNT_W'(DIFF_BYTES - 1));
   assign last_hdr  = (cnt_q == CNT_W'(HDR_BYTES - 1));

   // Final header byte is still on rx_data at commit time.
   always_comb begin
      hdr_full = hdr_sh_q;
      hdr_full[8*(HDR_BYTES-1) +: 8] = rx_data;
   end
   assign nonce_base = hdr_full[8*NONCE_OFS +: 32];

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
         to_d  = '0;
         if (write_enable) begin
            if (rx_data == PKT_NEW && !eop) state_d = RX_DIFF;
            else if (!eop)                  state_d = DRAIN;
         end
      end else if (write_enable) begin
         to_d = '0;
         unique case (state_q)
            RX_DIFF: begin
               if (eop) state_d = IDLE;
               else if (last_diff) begin
                  state_d = RX_HDR;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + CNT_W'(1);
            end
            RX_HDR: begin
               if (last_hdr)  state_d = eop ? IDLE : DRAIN;
               else if (eop)  state_d = IDLE;
               else           cnt_d   = cnt_q + CNT_W'(1);
            end
            default: if (eop) state_d = IDLE;
         endcase
      end else if (to_hit) begin
         state_d = IDLE;
         to_d    = '0;
      end else begin
         to_d = to_q + TO_W'(1);
      end
   end

   always_comb begin
      commit  = 1'b0;
      quit_d  = 1'b0;
      perr_d  = 1'b0;
      wr_diff = 1'b0;
      wr_hdr  = 1'b0;
      unique case (state_q)
         IDLE: if (write_enable) begin
            if (rx_data == PKT_ABORT && eop)    quit_d = 1'b1;
            else if (!(rx_data == PKT_NEW && !eop)) perr_d = 1'b1;
         end
         RX_DIFF: begin
            wr_diff = write_enable;
            perr_d  = (write_enable && eop) || to_hit;
         end
         RX_HDR: begin
            wr_hdr = write_enable;
            commit = write_enable && eop && last_hdr;
            perr_d = (write_enable && (eop != last_hdr)) || to_hit;
         end
         default: ;
      endcase
   end

   // Shadow capture and registered outputs.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         diff_sh_q  <= '0;
         hdr_sh_q   <= '0;
         header_out <= '0;
         difficulty <= '0;
         new_block  <= 1'b0;
         quit_hash  <= 1'b0;
         p_error    <= 1'b0;
         host_ready <= 1'b1;
      end else begin
         for (int k = 0; k < DIFF_BYTES; k++)
            if (wr_diff && cnt_q == CNT_W'(k)) diff_sh_q[8*(DIFF_BYTES-1-k) +: 8] <= rx_data;
         for (int k = 0; k < HDR_BYTES; k++)
            if (wr_hdr && cnt_q == CNT_W'(k)) hdr_sh_q[8*k +: 8] <= rx_data;
         if (commit) begin
            header_out <= hdr_full;
            difficulty <= diff_sh_q;
         end
         new_block  <= commit;
         quit_hash  <= quit_d;
         p_error    <= perr_d;
         host_ready <= (state_d == IDLE);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      pd_nonce_lane u_lane (
         .clk        (clk),
         .n_rst      (n_rst),
         .load_i     (commit),
         .load_val_i (nonce_base + 32'(c)),
         .inc_i      (increment[c]),
         .step_i     (32'(NUM_CH)),
         .value_o    (nonce[32*c +: 32]),
         .wrap_o     (nonce_wrap[c])
      );
   end

endmodule

// File: tb/tb_pd_block_decoder.sv
// Directed bench for pd_block_decoder with NUM_CH=2, TIMEOUT=16.
module tb_pd_block_decoder;
   import pd_pkg::*;

   localparam int unsigned NUM_CH = 2;
   localparam int unsigned DB     = 32;
   localparam int unsigned HB     = 80;
   localparam int unsigned NOFS   = 76;
   localparam int unsigned TMO    = 16;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              write_enable;
   logic [7:0]        rx_data;
   logic              eop;
   logic [NUM_CH-1:0] increment;
   logic [HB*8-1:0]   header_out;
   logic [DB*8-1:0]   difficulty;
   logic [NUM_CH*32-1:0] nonce;
   logic              new_block, quit_hash, p_error, host_ready;
   logic [NUM_CH-1:0] nonce_wrap;

   int n_tests = 0;
   int n_fail  = 0;

   pd_block_decoder #(
      .NUM_CH(NUM_CH), .DIFF_BYTES(DB), .HDR_BYTES(HB), .NONCE_OFS(NOFS), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .n_rst(n_rst), .write_enable(write_enable), .rx_data(rx_data), .eop(eop),
      .increment(increment), .header_out(header_out), .difficulty(difficulty), .nonce(nonce),
      .new_block(new_block), .quit_hash(quit_hash), .p_error(p_error),
      .nonce_wrap(nonce_wrap), .host_ready(host_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic e);
      @(negedge clk);
      write_enable = 1'b1;
      rx_data      = b;
      eop          = e;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      eop          = 1'b0;
   endtask

   function automatic logic [7:0] hdr_byte(input logic [7:0] seed, input logic [31:0] nb, input int k);
      if (k >= int'(NOFS) && k < int'(NOFS) + 4) return nb[8*(k-int'(NOFS)) +: 8];
      return seed + 8'(k);
   endfunction

   // Full packet; trunc >= 0 ends it early with eop on that header byte.
   task automatic send_pkt(input logic [7:0] seed, input logic [31:0] nb, input int trunc,
                           input logic [NUM_CH-1:0] inc_last);
      send(PKT_NEW, 1'b0);
      for (int i = 0; i < int'(DB); i++) send(8'h10 + seed + 8'(i), 1'b0);
      for (int k = 0; k < int'(HB); k++) begin
         if (k == trunc) begin
            send(hdr_byte(seed, nb, k), 1'b1);
            return;
         end
         if (k == int'(HB) - 1) begin
            increment = inc_last;
            send(hdr_byte(seed, nb, k), 1'b1);
            increment = '0;
         end else begin
            send(hdr_byte(seed, nb, k), 1'b0);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_inc(input logic [NUM_CH-1:0] v);
      @(negedge clk);
      increment = v;
      @(posedge clk);
      #1;
      increment = '0;
   endtask

   initial begin
      int perr_seen;
      n_rst = 1'b0; write_enable = 1'b0; rx_data = '0; eop = 1'b0; increment = '0;
      repeat (3) @(posedge clk);
      #1;
      n_rst = 1'b1;

      chk("rst_host_ready", 64'(host_ready), 64'd1);
      chk("rst_pulses", 64'({new_block, quit_hash, p_error, nonce_wrap}), 64'd0);
      chk("rst_nonce", 64'(nonce), 64'd0);
      chk("rst_hdr_diff", 64'({|header_out, |difficulty}), 64'd0);

      // Packet 1
      send(PKT_NEW, 1'b0);
      chk("rx_host_ready_low", 64'(host_ready), 64'd0);
      for (int i = 0; i < int'(DB); i++) send(8'h11 + 8'(i), 1'b0);
      for (int k = 0; k < int'(HB); k++) send(hdr_byte(8'h01, 32'h12345678, k), k == int'(HB) - 1);
      chk("p1_new_block", 64'(new_block), 64'd1);
      chk("p1_nonce0", 64'(nonce[31:0]), 64'h12345678);
      chk("p1_nonce1", 64'(nonce[63:32]), 64'h12345679);
      chk("p1_diff_msb", 64'(difficulty[DB*8-1 -: 8]), 64'h11);
      chk("p1_diff_lsb", 64'(difficulty[7:0]), 64'h30);
      chk("p1_hdr0", 64'(header_out[7:0]), 64'h01);
      chk("p1_hdr75", 64'(header_out[8*75 +: 8]), 64'h4C);
      chk("p1_hdr_nonce", 64'(header_out[8*NOFS +: 32]), 64'h12345678);
      chk("p1_host_ready", 64'(host_ready), 64'd1);
      step();
      chk("p1_new_block_once", 64'(new_block), 64'd0);

      repeat (3) pulse_inc(2'b01);
      chk("inc_nonce0", 64'(nonce[31:0]), 64'h1234567E);
      chk("inc_nonce1", 64'(nonce[63:32]), 64'h12345679);
      chk("inc_no_wrap", 64'(nonce_wrap), 64'd0);

      // Packet 2 truncated at header byte 40
      send_pkt(8'h40, 32'hDEADBEEF, 40, 2'b00);
      chk("trunc_perr", 64'(p_error), 64'd1);
      chk("trunc_no_commit", 64'(new_block), 64'd0);
      chk("trunc_hdr_kept", 64'(header_out[7:0]), 64'h01);
      chk("trunc_diff_kept", 64'(difficulty[DB*8-1 -: 8]), 64'h11);
      chk("trunc_host_ready", 64'(host_ready), 64'd1);
      step();
      chk("trunc_perr_pulse", 64'(p_error), 64'd0);

      // Wrap
      send_pkt(8'h20, 32'hFFFFFFFE, -1, 2'b00);
      chk("w_nonce0", 64'(nonce[31:0]), 64'hFFFFFFFE);
      chk("w_nonce1", 64'(nonce[63:32]), 64'hFFFFFFFF);
      pulse_inc(2'b01);
      chk("w_nonce0_wrapped", 64'(nonce[31:0]), 64'h0);
      chk("w_wrap0", 64'(nonce_wrap), 64'b01);
      pulse_inc(2'b10);
      chk("w_nonce1_wrapped", 64'(nonce[63:32]), 64'h1);
      chk("w_wrap1", 64'(nonce_wrap), 64'b10);
      step();
      chk("w_wrap_clear", 64'(nonce_wrap), 64'd0);

      // Increment together with commit
      send_pkt(8'h30, 32'hCAFEBABE, -1, 2'b11);
      chk("ic_new_block", 64'(new_block), 64'd1);
      chk("ic_nonce0", 64'(nonce[31:0]), 64'hCAFEBABE);
      chk("ic_nonce1", 64'(nonce[63:32]), 64'hCAFEBABF);

      // Timeout after difficulty byte 5
      send(PKT_NEW, 1'b0);
      for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), 1'b0);
      repeat (TMO - 1) step();
      chk("to_no_perr_yet", 64'(p_error), 64'd0);
      chk("to_still_busy", 64'(host_ready), 64'd0);
      step();
      chk("to_perr", 64'(p_error), 64'd1);
      chk("to_host_ready", 64'(host_ready), 64'd1);
      repeat (4) step();
      chk("to_perr_once", 64'(p_error), 64'd0);
      send_pkt(8'h50, 32'h00000010, -1, 2'b00);
      chk("to_recover_nb", 64'(new_block), 64'd1);
      chk("to_recover_nonce0", 64'(nonce[31:0]), 64'h10);
      chk("to_recover_hdr0", 64'(header_out[7:0]), 64'h50);
      chk("to_recover_diff", 64'(difficulty[DB*8-1 -: 8]), 64'h60);

      // Bad type byte, drain, then abort
      send(8'h33, 1'b0);
      chk("bad_perr", 64'(p_error), 64'd1);
      chk("bad_drain", 64'(host_ready), 64'd0);
      perr_seen = 0;
      for (int i = 0; i < 10; i++) begin
         send((i == 3) ? PKT_NEW : 8'h70 + 8'(i), 1'b0);
         if (p_error || new_block) perr_seen++;
      end
      send(8'h77, 1'b1);
      if (p_error || new_block) perr_seen++;
      chk("drain_quiet", 64'(perr_seen), 64'd0);
      chk("drain_idle", 64'(host_ready), 64'd1);
      send(PKT_ABORT, 1'b1);
      chk("abort_quit", 64'(quit_hash), 64'd1);
      chk("abort_no_perr", 64'(p_error), 64'd0);
      step();
      chk("abort_quit_pulse", 64'(quit_hash), 64'd0);

      // New-type byte with eop is an error and stays idle
      send(PKT_NEW, 1'b1);
      chk("a5eop_perr", 64'(p_error), 64'd1);
      chk("a5eop_idle", 64'(host_ready), 64'd1);

      // Timeout inside DRAIN is silent
      send(8'h33, 1'b0);
      perr_seen = 0;
      for (int i = 0; i < int'(TMO); i++) begin
         step();
         if (p_error) perr_seen++;
      end
      chk("drain_to_quiet", 64'(perr_seen), 64'd0);
      chk("drain_to_idle", 64'(host_ready), 64'd1);

      // Reset mid-packet
      send(PKT_NEW, 1'b0);
      send(8'h01, 1'b0);
      @(negedge clk);
      n_rst = 1'b0;
      step();
      n_rst = 1'b1;
      chk("mid_rst_idle", 64'(host_ready), 64'd1);
      chk("mid_rst_pulses", 64'({new_block, quit_hash, p_error}), 64'd0);
      chk("mid_rst_nonce", 64'(nonce), 64'd0);
      send_pkt(8'h05, 32'h00000100, -1, 2'b00);
      chk("post_rst_nonce1", 64'(nonce[63:32]), 64'h101);
      chk("post_rst_diff", 64'(difficulty[DB*8-1 -: 8]), 64'h15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
